// File: rtl/router_mem_arbiter.sv
// Round-robin arbiter sharing one packet-buffer port: setup cycle, fixed-length burst, release.
// Optional completed-burst counter on burst_count when MEM_ARB_PERF_EN is defined.
module router_mem_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BURST_LEN  = 19
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_rd,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt_rd,
    output logic [NUM_REQ-1:0]            gnt_wr,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          burst_last,
    output logic                          busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]                   burst_count
`endif
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN + 1) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {StIdle, StGrant, StBurst, StRelease} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        winner_q, last_win_q;
    logic                    op_rd_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [BEAT_W-1:0]       beat_q;

    logic                    arb_found;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_rd;
    logic [ADDR_WIDTH-1:0]   arb_addr;
    int unsigned             cand;
    logic                    win_req;
    logic                    granted;
    logic [NUM_REQ-1:0]      gnt_vec;

    // Search starts just after the previous winner and wraps modulo NUM_REQ.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_rd    = 1'b0;
        arb_addr  = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(last_win_q) + 32'd1 + k) % NUM_REQ;
            if (!arb_found && (req_rd[IDX_W'(cand)] || req_wr[IDX_W'(cand)])) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'(cand);
                arb_rd    = req_rd[IDX_W'(cand)];
                arb_addr  = req_addr[cand*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign win_req = op_rd_q ? req_rd[winner_q] : req_wr[winner_q];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (arb_found) state_d = StGrant;
            StGrant:   state_d = StBurst;
            StBurst:   if (beat_q == LAST_BEAT || !win_req) state_d = StRelease;
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            winner_q   <= '0;
            last_win_q <= IDX_W'(NUM_REQ - 1);
            op_rd_q    <= 1'b0;
            addr_q     <= '0;
            beat_q     <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (arb_found) begin
                        winner_q <= arb_idx;
                        op_rd_q  <= arb_rd;
                        addr_q   <= arb_addr;
                    end
                end
                StBurst: begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    beat_q <= beat_q + BEAT_W'(1);
                end
                StRelease: begin
                    last_win_q <= winner_q;
                    beat_q     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign granted    = (state_q == StGrant) || (state_q == StBurst);
    assign gnt_vec    = granted ? (NUM_REQ'(1) << winner_q) : '0;
    assign gnt_rd     = op_rd_q ? gnt_vec : '0;
    assign gnt_wr     = op_rd_q ? '0 : gnt_vec;
    assign mem_en     = (state_q == StBurst);
    assign mem_we     = mem_en && !op_rd_q;
    assign mem_addr   = mem_en ? addr_q : '0;
    assign burst_last = mem_en && (beat_q == LAST_BEAT);
    assign busy       = (state_q != StIdle);

`ifdef MEM_ARB_PERF_EN
    logic [15:0] burst_count_q;

    // Aborted bursts still pass through RELEASE, so they are counted too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_count_q <= '0;
        end else if (state_q == StRelease && burst_count_q != 16'hFFFF) begin
            burst_count_q <= burst_count_q + 16'd1;
        end
    end

    assign burst_count = burst_count_q;
`endif

endmodule

// File: tb/tb_router_mem_arbiter.sv
// Directed bench for router_mem_arbiter: reset, single read, round-robin, wrap, abort,
// read/write tie and reset mid-burst.
module tb_router_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_rd = '0;
    logic [3:0]  req_wr = '0;
    logic [39:0] req_addr = '0;
    logic [3:0]  gnt_rd, gnt_wr;
    logic        mem_en, mem_we, burst_last, busy;
    logic [9:0]  mem_addr;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] burst_count;
`endif

    int checks = 0;
    int failures = 0;

    router_mem_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(10), .BURST_LEN(19)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .gnt_rd     (gnt_rd),
        .gnt_wr     (gnt_wr),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .burst_last (burst_last),
        .busy       (busy)
`ifdef MEM_ARB_PERF_EN
        ,
        .burst_count(burst_count)
`endif
    );

    always #5 clk = ~clk;

    wire [21:0] obs = {gnt_rd, gnt_wr, mem_en, mem_we, mem_addr, burst_last, busy};

    function automatic logic [21:0] ev(input logic [3:0] gr, input logic [3:0] gw,
                                       input logic en, input logic we, input logic [9:0] a,
                                       input logic last, input logic bz);
        return {gr, gw, en, we, a, last, bz};
    endfunction

    task automatic do_reset();
        req_rd = '0;
        req_wr = '0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [21:0] e;
        req_rd = 4'hF;
        rst_n  = 1'b0;
        @(negedge clk);
        e = '0;
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", obs, e);
        end
`ifdef MEM_ARB_PERF_EN
        checks++;
        if (burst_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", burst_count);
        end
`endif
        req_rd = '0;
        rst_n  = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL idle_no_req got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_single_read();
        logic [21:0] e;
        do_reset();
        req_addr[9:0] = 10'h100;
        req_rd = 4'b0001;
        @(negedge clk);
        e = ev(4'b0001, 4'b0000, 1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL single_grant got=%h exp=%h", obs, e);
        end
        for (int b = 0; b < 19; b++) begin
            @(negedge clk);
            e = ev(4'b0001, 4'b0000, 1'b1, 1'b0, 10'(10'h100 + b), b == 18, 1'b1);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL single_beat b=%0d got=%h exp=%h", b, obs, e);
            end
        end
        @(negedge clk);
        req_rd = '0;
        e = ev(4'b0, 4'b0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL single_release got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        checks++;
        if (obs !== 22'h0) begin
            failures++;
            $display("FAIL single_idle got=%h exp=0", obs);
        end
    endtask

    task automatic test_round_robin();
        logic [21:0] e;
        logic [3:0]  oh;
        int          w;
        do_reset();
        for (int i = 0; i < 4; i++) req_addr[i*10 +: 10] = 10'(i * 64);
        req_wr = 4'hF;
        for (int g = 0; g < 5; g++) begin
            w  = g % 4;
            oh = 4'(1 << w);
            @(negedge clk);
            e = ev(4'b0, oh, 1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL rr_grant g=%0d got=%h exp=%h", g, obs, e);
            end
            for (int b = 0; b < 19; b++) begin
                @(negedge clk);
                e = ev(4'b0, oh, 1'b1, 1'b1, 10'(w * 64 + b), b == 18, 1'b1);
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL rr_beat g=%0d b=%0d got=%h exp=%h", g, b, obs, e);
                end
            end
            @(negedge clk);
            if (g == 4) req_wr = '0;
            e = ev(4'b0, 4'b0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL rr_release g=%0d got=%h exp=%h", g, obs, e);
            end
            @(negedge clk);
            checks++;
            if (obs !== 22'h0) begin
                failures++;
                $display("FAIL rr_idle g=%0d got=%h exp=0", g, obs);
            end
        end
    endtask

    task automatic test_wrap();
        logic [21:0] e;
        do_reset();
        req_addr[29:20] = 10'h3FA;
        req_rd = 4'b0100;
        @(negedge clk);
        e = ev(4'b0100, 4'b0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL wrap_grant got=%h exp=%h", obs, e);
        end
        for (int b = 0; b < 19; b++) begin
            @(negedge clk);
            e = ev(4'b0100, 4'b0, 1'b1, 1'b0, 10'(10'h3FA + b), b == 18, 1'b1);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL wrap_beat b=%0d got=%h exp=%h", b, obs, e);
            end
        end
        @(negedge clk);
        req_rd = '0;
        @(negedge clk);
        checks++;
        if (obs !== 22'h0) begin
            failures++;
            $display("FAIL wrap_idle got=%h exp=0", obs);
        end
    endtask

    task automatic test_abort();
        logic [21:0] e;
        do_reset();
        req_addr[19:10] = 10'h020;
        req_addr[39:30] = 10'h2C0;
        req_rd = 4'b1010;
        @(negedge clk);
        e = ev(4'b0010, 4'b0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL abort_grant got=%h exp=%h", obs, e);
        end
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            e = ev(4'b0010, 4'b0, 1'b1, 1'b0, 10'(10'h020 + b), 1'b0, 1'b1);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL abort_beat b=%0d got=%h exp=%h", b, obs, e);
            end
        end
        req_rd = 4'b1000;
        @(negedge clk);
        e = ev(4'b0, 4'b0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL abort_release got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        checks++;
        if (obs !== 22'h0) begin
            failures++;
            $display("FAIL abort_idle got=%h exp=0", obs);
        end
        @(negedge clk);
        e = ev(4'b1000, 4'b0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL abort_next_grant got=%h exp=%h", obs, e);
        end
        req_rd = '0;
        @(negedge clk);
        e = ev(4'b1000, 4'b0, 1'b1, 1'b0, 10'h2C0, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL abort_next_beat got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        e = ev(4'b0, 4'b0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL abort_next_release got=%h exp=%h", obs, e);
        end
        @(negedge clk);
    endtask

    task automatic test_rd_wr_tie();
        logic [21:0] e;
        logic [3:0]  gr, gw;
        do_reset();
        req_addr[9:0] = 10'h050;
        req_rd = 4'b0001;
        req_wr = 4'b0001;
        for (int p = 0; p < 2; p++) begin
            gr = (p == 0) ? 4'b0001 : 4'b0000;
            gw = (p == 0) ? 4'b0000 : 4'b0001;
            @(negedge clk);
            e = ev(gr, gw, 1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL tie_grant p=%0d got=%h exp=%h", p, obs, e);
            end
            for (int b = 0; b < 19; b++) begin
                @(negedge clk);
                e = ev(gr, gw, 1'b1, p == 1, 10'(10'h050 + b), b == 18, 1'b1);
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL tie_beat p=%0d b=%0d got=%h exp=%h", p, b, obs, e);
                end
            end
            @(negedge clk);
            if (p == 0) req_rd = '0;
            else req_wr = '0;
            @(negedge clk);
            checks++;
            if (obs !== 22'h0) begin
                failures++;
                $display("FAIL tie_idle p=%0d got=%h exp=0", p, obs);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [21:0] e;
        do_reset();
        req_addr[39:30] = 10'h200;
        req_rd = 4'b1000;
        @(negedge clk);
        for (int b = 0; b < 11; b++) begin
            @(negedge clk);
            e = ev(4'b1000, 4'b0, 1'b1, 1'b0, 10'(10'h200 + b), 1'b0, 1'b1);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL mid_beat b=%0d got=%h exp=%h", b, obs, e);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 22'h0) begin
            failures++;
            $display("FAIL mid_async_reset got=%h exp=0", obs);
        end
`ifdef MEM_ARB_PERF_EN
        checks++;
        if (burst_count !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset_count got=%0d exp=0", burst_count);
        end
`endif
        @(negedge clk);
        checks++;
        if (obs !== 22'h0) begin
            failures++;
            $display("FAIL mid_held_reset got=%h exp=0", obs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        e = ev(4'b1000, 4'b0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL mid_regrant got=%h exp=%h", obs, e);
        end
        for (int b = 0; b < 19; b++) begin
            @(negedge clk);
            e = ev(4'b1000, 4'b0, 1'b1, 1'b0, 10'(10'h200 + b), b == 18, 1'b1);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL mid_rebeat b=%0d got=%h exp=%h", b, obs, e);
            end
        end
        @(negedge clk);
        req_rd = '0;
        @(negedge clk);
        checks++;
        if (obs !== 22'h0) begin
            failures++;
            $display("FAIL mid_idle got=%h exp=0", obs);
        end
`ifdef MEM_ARB_PERF_EN
        checks++;
        if (burst_count !== 16'd1) begin
            failures++;
            $display("FAIL mid_count got=%0d exp=1", burst_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_wrap();
        test_abort();
        test_rd_wr_tie();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
